wb_port_arbiter: RTL

Shares the single register-file write port between the core's single-cycle writeback and a long-latency unit such as a divider or a slow load return. The core's writeback value is the already-muxed dataW, and it has priority. Long-latency results are held in a one-entry buffer and drained into idle write-port cycles. A starvation counter forces a one-cycle core stall if the buffer waits too long. The block sits between the writeback data mux and the register file.

---
 rtl/riscv_wb_pkg.sv | 6 +
 rtl/wb_port_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg: shared widths and writeback-arbiter state encoding.
package riscv_wb_pkg;
    localparam int XLEN = 32;
    localparam int RA_W = 5;
    typedef enum logic [1:0] {IDLE, PEND, FORCE} wb_arb_state_t;
endpackage

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between core writeback and a one-entry long-latency buffer.
// Optional WB_ARB_FWD_EN adds a forwarding path out of the pending buffer.
module wb_port_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_we,
    input  logic [RA_W-1:0] core_rd,
    input  logic [XLEN-1:0] core_data,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic [RA_W-1:0] lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            core_stall
`ifdef WB_ARB_FWD_EN
    ,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd_data
`endif
);
    wb_arb_state_t   state_q, state_d;
    logic            buf_valid_q, buf_valid_d;
    logic [RA_W-1:0] buf_rd_q, buf_rd_d;
    logic [XLEN-1:0] buf_data_q, buf_data_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            core_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_rd_q    <= '0;
            buf_data_q  <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_rd_q    <= buf_rd_d;
            buf_data_q  <= buf_data_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign lu_ready = !buf_valid_q;
    assign core_wr  = core_we && core_rd != '0;

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_rd_d    = buf_rd_q;
        buf_data_d  = buf_data_q;
        wait_cnt_d  = wait_cnt_q;
        rf_we       = core_wr;
        rf_rd       = core_rd;
        rf_wdata    = core_data;
        core_stall  = 1'b0;
        case (state_q)
            IDLE: begin
                // rd=0 results are handshake-only; a same-cycle core write to lu_rd is younger and wins
                if (lu_valid && lu_ready && lu_rd != '0 && !(core_wr && core_rd == lu_rd)) begin
                    state_d     = PEND;
                    buf_valid_d = 1'b1;
                    buf_rd_d    = lu_rd;
                    buf_data_d  = lu_data;
                    wait_cnt_d  = '0;
                end
            end
            PEND: begin
                if (!core_wr) begin
                    rf_we       = 1'b1;
                    rf_rd       = buf_rd_q;
                    rf_wdata    = buf_data_q;
                    state_d     = IDLE;
                    buf_valid_d = 1'b0;
                    wait_cnt_d  = '0;
                end else if (core_rd == buf_rd_q) begin
                    state_d     = IDLE;
                    buf_valid_d = 1'b0;
                    wait_cnt_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                    state_d    = (wait_cnt_q == 4'(MAX_WAIT - 1)) ? FORCE : PEND;
                end
            end
            FORCE: begin
                rf_we       = 1'b1;
                rf_rd       = buf_rd_q;
                rf_wdata    = buf_data_q;
                core_stall  = 1'b1;
                state_d     = IDLE;
                buf_valid_d = 1'b0;
                wait_cnt_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        rf_we = rf_we && rst_n;
    end

`ifdef WB_ARB_FWD_EN
    assign fwd1_hit = buf_valid_q && rs1 == buf_rd_q && rs1 != '0;
    assign fwd2_hit = buf_valid_q && rs2 == buf_rd_q && rs2 != '0;
    assign fwd_data = buf_data_q;
`endif
endmodule
